wb_daq_channel_scheduler: RTL
=============================

// Module: wb_daq_channel_scheduler
// PURPOSE
//  Wishbone-master DMA scheduler for the 4 DAQ channels. Consumes the daq_control / channelN
//  address / channelN control registers and grants the channels round-robin access to one WB
//  master port. Each granted sample is written to that channel's running address; the block
//  counts transfers, raises done/error status and an interrupt. Status feeds the
//  channelN status inputs of the slave register block.
// PARAMETERS
//  dw     32  data/address width (fixed 32; byte address, word stride 4)
//  NCH    4   channel count (fixed 4)
// PORTS
//  wb_clk            in   1       clock
//  wb_rst            in   1       asynchronous reset, active high
//  daq_control_reg   in   dw      [0] global enable
//  chN_address_reg   in   dw      N=0..3, start byte address (loaded on channel start)
//  chN_control_reg   in   dw      N=0..3: [0] enable, [1] irq_en, [31:16] length in words (0 = continuous)
//  ch_req            in   NCH     per-channel sample-ready level; held until ch_ack
//  ch_data           in   NCH*dw  packed samples, ch n at [n*dw +: dw]
//  ch_ack            out  NCH     1-cycle pulse: sample of ch n written (or dropped on error)
//  chN_status_reg    out  dw      N=0..3: [31:16] count, [2] busy, [1] err, [0] done
//  wbm_adr_o         out  dw      WB master address
//  wbm_dat_o         out  dw      WB master write data
//  wbm_sel_o         out  4       always 4'hF during a cycle
//  wbm_we_o/cyc_o/stb_o out 1     WB master strobes (we=1 whenever cyc=1)
//  wbm_ack_i/err_i   in   1       WB master termination
//  interrupt         out  1       registered OR over n of (done|err)&irq_en
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, rr pointer = 3 (ch0 wins first), counts/addresses 0.
//  Channel start: enable 0->1 (registered edge detect) while not active -> cur_addr=address_reg,
//   count=0, done=err=0, active=1. enable 1->0 -> active=0, done/err cleared next cycle.
//  Eligible n = global_en & active[n] & ch_req[n] & ~done[n] & ~err[n].
//  FSM IDLE: any eligible -> ARB. ARB (1 cycle): pick first eligible after rr pointer
//   (wrap 3->0), latch gnt, adr=cur_addr[gnt], dat=ch_data[gnt] -> WRITE; none eligible -> IDLE.
//  WRITE: cyc=stb=we=1, sel=F, adr/dat stable until termination; wait unbounded.
//   ack -> UPDATE; err -> err[gnt]=1, ch_ack[gnt] pulse, -> IDLE (no addr/count change).
//   ack and err same cycle: err wins.
//  UPDATE (1 cycle): cyc/stb low; cur_addr+=4 (wraps mod 2^32); count+=1 (16-bit, wraps only
//   when length=0); ch_ack[gnt] pulse; rr pointer=gnt; if length!=0 and count+1==length -> done=1.
//   -> ARB if any eligible else IDLE. Min 3 cycles/sample with zero-wait slave.
//  Status: busy[n]=1 while gnt==n in ARB..UPDATE; count mirrors internal counter.
//  Mid-transfer enable/global_en drop: current WB cycle completes normally (ack pulse, count
//   update), then channel is ineligible. Enable re-toggle restarts from address_reg.
//  ch_req dropping while granted: data already latched, write still completes.
//  interrupt: registered, level, falls 1 cycle after sources clear (via enable drop).
//  Reset mid-cycle: cyc/stb deassert asynchronously with reset.
// STRUCTURE
//  wb_daq_scheduler_include.vh: FSM state encodings, control/status field bit positions,
//   WORD_STRIDE=4.
//  Sub-module wb_daq_rr_arbiter: NCH req + pointer -> one-hot grant + valid, combinational.
//  Top holds FSM, per-channel addr/count/flag registers and WB master outputs.
// TESTING
//  1 ch0 en, len=3, addr=0x1000, req held, 0-wait slave -> writes 0x1000,0x1004,0x1008;
//    done=1, count=3, no 4th write; irq_en=1 -> interrupt=1.
//  2 all 4 en, len=0, req held -> grant order 0,1,2,3,0,1...; each adr advances by 4 per grant.
//  3 slave inserts 5 wait states -> adr/dat/stb stable for 6 cycles, single ch_ack pulse.
//  4 err on ch2 2nd write (addr 0x2004) -> err=1, ch2 skipped, others continue; re-toggle
//    enable -> restarts at 0x2000, count=0.
//  5 ch1 enable drops in WRITE -> write completes, count increments, then no further grants.
//  6 async reset asserted during WRITE -> cyc/stb low same cycle, status 0, ch0 first after.

Source files
------------

// File: rtl/wb_daq_channel_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_daq_channel_scheduler_pkg
// Purpose : Shared constants, FSM state type and helpers for the DAQ channel
//           Wishbone DMA scheduler.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package wb_daq_channel_scheduler_pkg;

  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int CH_IDX_W = 2;

  localparam logic [DW-1:0] WORD_STRIDE = 32'd4;

  // Control register fields
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_IRQ_BIT = 1;
  localparam int CTRL_LEN_LSB = 16;

  // Status register fields
  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;
  localparam int STAT_BUSY_BIT = 2;
  localparam int STAT_CNT_LSB  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_WRITE  = 2'd2,
    ST_UPDATE = 2'd3
  } sched_state_t;

  // One-hot grant to channel index; returns 0 for an all-zero input.
  function automatic logic [CH_IDX_W-1:0] onehot_to_idx(input logic [NCH-1:0] oh);
    logic [CH_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (oh[i]) idx = idx | CH_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_daq_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_daq_rr_arbiter
// Purpose : Combinational round-robin arbiter. Grants the first requester
//           strictly after the pointer, wrapping NCH-1 -> 0.
// Ports   : req_i   NCH  request vector
//           ptr_i   2    last-served channel
//           gnt_o   NCH  one-hot grant
//           valid_o 1    any grant issued
// Revision: 1.0 - initial release
// ============================================================================
module wb_daq_rr_arbiter
  import wb_daq_channel_scheduler_pkg::*;
(
  input  logic [NCH-1:0]      req_i,
  input  logic [CH_IDX_W-1:0] ptr_i,
  output logic [NCH-1:0]      gnt_o,
  output logic                valid_o
);

  logic [CH_IDX_W-1:0] w_idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    w_idx   = '0;
    // Offsets 1..NCH so the pointer channel itself is considered last.
    for (int i = 1; i <= NCH; i++) begin
      w_idx = ptr_i + CH_IDX_W'(i);
      if (!valid_o && req_i[w_idx]) begin
        gnt_o[w_idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_daq_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : wb_daq_channel_scheduler
// Purpose : Wishbone-master DMA scheduler for 4 DAQ channels. Grants channels
//           round-robin, writes each sample to the channel's running address,
//           tracks per-channel count/done/error and raises an interrupt.
// Ports   : wb_clk/wb_rst          clock, async active-high reset
//           daq_control_reg        [0] global enable
//           chN_address_reg        start byte address per channel
//           chN_control_reg        [0] en, [1] irq_en, [31:16] length (0=cont.)
//           ch_req/ch_data/ch_ack  per-channel sample handshake
//           chN_status_reg         [31:16] count, [2] busy, [1] err, [0] done
//           wbm_*                  Wishbone master write port
//           interrupt              registered OR of (done|err)&irq_en
// Revision: 1.0 - initial release
// ============================================================================
module wb_daq_channel_scheduler
  import wb_daq_channel_scheduler_pkg::*;
(
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic [DW-1:0]     daq_control_reg,
  input  logic [DW-1:0]     ch0_address_reg,
  input  logic [DW-1:0]     ch1_address_reg,
  input  logic [DW-1:0]     ch2_address_reg,
  input  logic [DW-1:0]     ch3_address_reg,
  input  logic [DW-1:0]     ch0_control_reg,
  input  logic [DW-1:0]     ch1_control_reg,
  input  logic [DW-1:0]     ch2_control_reg,
  input  logic [DW-1:0]     ch3_control_reg,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*DW-1:0] ch_data,
  output logic [NCH-1:0]    ch_ack,
  output logic [DW-1:0]     ch0_status_reg,
  output logic [DW-1:0]     ch1_status_reg,
  output logic [DW-1:0]     ch2_status_reg,
  output logic [DW-1:0]     ch3_status_reg,
  output logic [DW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  output logic [3:0]        wbm_sel_o,
  output logic              wbm_we_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic              interrupt
);

  logic [DW-1:0] w_addr_reg [NCH];
  logic [DW-1:0] w_ctl_reg  [NCH];
  logic [DW-1:0] w_status   [NCH];

  assign w_addr_reg[0] = ch0_address_reg;
  assign w_addr_reg[1] = ch1_address_reg;
  assign w_addr_reg[2] = ch2_address_reg;
  assign w_addr_reg[3] = ch3_address_reg;
  assign w_ctl_reg[0]  = ch0_control_reg;
  assign w_ctl_reg[1]  = ch1_control_reg;
  assign w_ctl_reg[2]  = ch2_control_reg;
  assign w_ctl_reg[3]  = ch3_control_reg;

  sched_state_t        state_q, state_d;
  logic [CH_IDX_W-1:0] gnt_q, gnt_d, rr_q, rr_d;
  logic [DW-1:0]       adr_q, adr_d, dat_q, dat_d;
  logic [NCH-1:0]      en_q, en_d, active_q, active_d, done_q, done_d, err_q, err_d;
  logic [DW-1:0]       cur_addr_q [NCH];
  logic [DW-1:0]       cur_addr_d [NCH];
  logic [15:0]         count_q [NCH];
  logic [15:0]         count_d [NCH];
  logic                irq_q;

  logic [NCH-1:0]      w_elig, w_arb_gnt, w_irq_en, w_busy;
  logic                w_arb_valid;
  logic [CH_IDX_W-1:0] w_arb_idx;
  logic                w_upd_fire, w_err_fire;

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      w_elig[n]   = daq_control_reg[CTRL_EN_BIT] & active_q[n] & ch_req[n] & ~done_q[n] & ~err_q[n];
      w_irq_en[n] = w_ctl_reg[n][CTRL_IRQ_BIT];
    end
  end

  wb_daq_rr_arbiter u_arb (
    .req_i   (w_elig),
    .ptr_i   (rr_q),
    .gnt_o   (w_arb_gnt),
    .valid_o (w_arb_valid)
  );

  assign w_arb_idx  = onehot_to_idx(w_arb_gnt);
  assign w_upd_fire = (state_q == ST_UPDATE);
  assign w_err_fire = (state_q == ST_WRITE) && wbm_err_i;

  // Scheduler FSM: next state, latched transfer and ch_ack pulse.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    ch_ack  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|w_elig) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (w_arb_valid) begin
          gnt_d   = w_arb_idx;
          adr_d   = cur_addr_q[w_arb_idx];
          dat_d   = ch_data[{w_arb_idx, 5'b0} +: DW];
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // Error takes priority over a simultaneous ack; the sample is dropped.
        if (wbm_err_i) begin
          ch_ack[gnt_q] = 1'b1;
          state_d       = ST_IDLE;
        end else if (wbm_ack_i) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        ch_ack[gnt_q] = 1'b1;
        rr_d          = gnt_q;
        state_d       = (|w_elig) ? ST_ARB : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-channel address/count/flag next state.
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      en_d[n]       = w_ctl_reg[n][CTRL_EN_BIT];
      active_d[n]   = active_q[n];
      done_d[n]     = done_q[n];
      err_d[n]      = err_q[n];
      cur_addr_d[n] = cur_addr_q[n];
      count_d[n]    = count_q[n];
      if (w_upd_fire && (gnt_q == CH_IDX_W'(n))) begin
        cur_addr_d[n] = cur_addr_q[n] + WORD_STRIDE;
        count_d[n]    = count_q[n] + 16'd1;
        if ((w_ctl_reg[n][DW-1:CTRL_LEN_LSB] != 16'd0) &&
            (count_q[n] + 16'd1 == w_ctl_reg[n][DW-1:CTRL_LEN_LSB]))
          done_d[n] = 1'b1;
      end
      if (w_err_fire && (gnt_q == CH_IDX_W'(n))) err_d[n] = 1'b1;
      // Enable low deactivates and clears flags; the count is kept for readback.
      if (!w_ctl_reg[n][CTRL_EN_BIT]) begin
        active_d[n] = 1'b0;
        done_d[n]   = 1'b0;
        err_d[n]    = 1'b0;
      end else if (!en_q[n] && !active_q[n]) begin
        active_d[n]   = 1'b1;
        done_d[n]     = 1'b0;
        err_d[n]      = 1'b0;
        cur_addr_d[n] = w_addr_reg[n];
        count_d[n]    = 16'd0;
      end
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_q     <= CH_IDX_W'(NCH - 1);
      adr_q    <= '0;
      dat_q    <= '0;
      en_q     <= '0;
      active_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      irq_q    <= 1'b0;
      for (int n = 0; n < NCH; n++) begin
        cur_addr_q[n] <= '0;
        count_q[n]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      en_q     <= en_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_q    <= |((done_q | err_q) & w_irq_en);
      for (int n = 0; n < NCH; n++) begin
        cur_addr_q[n] <= cur_addr_d[n];
        count_q[n]    <= count_d[n];
      end
    end
  end

  // Busy covers the arbitration cycle (live grant) and the latched grant after.
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      w_busy[n] = ((state_q == ST_ARB) && w_arb_valid && w_arb_gnt[n]) ||
                  (((state_q == ST_WRITE) || (state_q == ST_UPDATE)) && (gnt_q == CH_IDX_W'(n)));
      w_status[n] = {count_q[n], 13'd0, w_busy[n], err_q[n], done_q[n]};
    end
  end

  assign ch0_status_reg = w_status[0];
  assign ch1_status_reg = w_status[1];
  assign ch2_status_reg = w_status[2];
  assign ch3_status_reg = w_status[3];

  // Strobes decode straight from the state register so reset drops them at once.
  assign wbm_cyc_o = (state_q == ST_WRITE);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = wbm_cyc_o;
  assign wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign interrupt = irq_q;

  logic unused_bits;
  assign unused_bits = ^{daq_control_reg[DW-1:1],
                         ch0_control_reg[15:2], ch1_control_reg[15:2],
                         ch2_control_reg[15:2], ch3_control_reg[15:2]};

endmodule
`default_nettype wire
